ex_mem_pipe_reg: RTL and testbench
==================================

Name: ex_mem_pipe_reg

Overview:
- Parametrised EX/MEM pipeline register. It is the successor of the fixed-width EX/MEM latch.
- Carries register-writeback and HI/LO payload from EX to MEM, with a valid bit.
- Honours the CTRL stall vector at a configurable stage index and adds a synchronous flush.
- Holds multi-cycle arithmetic state (accumulator plus step counter) across stalls, and exposes a saturating stall-duration counter for the performance/debug logic.

Parameters:
- DATA_W, 32, width of wdata/hi/lo
- ADDR_W, 5, destination register address width
- STALL_W, 6, width of CTRL stall vector
- STAGE, 3, index of this register's stage in stall vector; STAGE+1 must be < STALL_W
- CNT_W, 2, multi-cycle step counter width
- SCNT_W, 8, stall-duration counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  STALL_W  CTRL stall vector, 1 = Stop
- flush  in  1  synchronous pipeline flush (exception/redirect)
- ex_valid  in  1  EX holds a real instruction
- ex_wd  in  ADDR_W  destination register
- ex_wdata  in  DATA_W  writeback data
- ex_wreg  in  1  register write enable
- ex_hi, ex_lo  in  DATA_W each  HI/LO results
- ex_whilo  in  1  HI/LO write enable
- acc_i  in  2*DATA_W  in-progress multi-cycle accumulator from EX
- cnt_i  in  CNT_W  in-progress step count from EX
- acc_o  out  2*DATA_W  accumulator returned to EX
- cnt_o  out  CNT_W  step count returned to EX
- mem_valid  out  1  MEM-side valid
- mem_wd, mem_wdata, mem_wreg, mem_hi, mem_lo, mem_whilo  out  as inputs  payload to MEM
- stall_cycles  out  SCNT_W  consecutive cycles stall[STAGE] has been 1
- stall_sat  out  1  stall_cycles reached all-ones

Behaviour:
- Reset (async, immediate on rst=1):
  - All outputs are 0, including mem_valid, acc_o, cnt_o, stall_cycles and stall_sat.
  - Deasserting rst mid-operation resumes from this zero state; no partial payload survives.
- Let s0 = stall[STAGE] and s1 = stall[STAGE+1]. On each rising clk edge exactly one action applies, in this priority:
  1. FLUSH (flush=1):
     - Payload and mem_valid cleared; acc_o=0, cnt_o=0 (in-flight multi-cycle op aborted).
     - stall_cycles=0. Flush overrides any stall pattern.
  2. BUBBLE (s0=1, s1=0):
     - Payload and mem_valid cleared.
     - acc_o<=acc_i, cnt_o<=cnt_i.
  3. ADVANCE (s0=0):
     - mem_* <= ex_*; mem_valid <= ex_valid.
     - acc_o=0, cnt_o=0.
  4. HOLD (s0=1, s1=1):
     - Payload and mem_valid unchanged.
     - acc_o<=acc_i, cnt_o<=cnt_i.
- Payload gating in ADVANCE: if ex_valid=0, mem_wreg and mem_whilo are forced to 0 (data fields still captured).
- stall_cycles:
  - +1 on each edge with s0=1 and no flush; saturates at 2^SCNT_W-1 (no wrap).
  - Cleared on ADVANCE or FLUSH.
  - stall_sat = (stall_cycles == all-ones), registered alongside.
- Latency: 1 cycle EX→MEM on ADVANCE. Outputs change only on clk edges or async reset.
- No combinational path from any input to any output.

Test Plan:
- Reset: drive ex_wdata=32'hDEADBEEF, ex_wreg=1, stall=0, then assert rst between edges → all outputs 0 immediately, before the next edge.
- Advance: stall=0, ex_valid=1, ex_wd=5'd7, ex_wdata=32'h12345678, ex_wreg=1 → next cycle mem_wd=7, mem_wdata=32'h12345678, mem_wreg=1, mem_valid=1, acc_o=0, cnt_o=0.
- Bubble with accumulator carry: stall=6'b001111, acc_i=64'h0000_0001_0000_0002, cnt_i=2'b01 → mem_valid=0, mem_wreg=0, acc_o=64'h0000_0001_0000_0002, cnt_o=1.
- Hold: after an ADVANCE loading mem_wdata=32'hA5A5A5A5, apply stall=6'b011111 for 3 cycles with ex_wdata changing → mem_wdata stays 32'hA5A5A5A5, stall_cycles=3, then stall=0 → stall_cycles=0, new data captured.
- Flush priority: stall=6'b001111 with acc_i nonzero and flush=1 → acc_o=0, cnt_o=0, mem_valid=0, stall_cycles=0.
- Saturation and invalid gating: with SCNT_W=4, hold s0=1 for 20 cycles → stall_cycles=15, stall_sat=1. Then ADVANCE with ex_valid=0, ex_wreg=1, ex_whilo=1 → mem_wreg=0, mem_whilo=0, mem_valid=0.

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: carries writeback and HI/LO payload with a valid bit,
// honours the CTRL stall vector, supports flush and keeps multi-cycle arithmetic state.
module ex_mem_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6,
    parameter int STAGE   = 3,
    parameter int CNT_W   = 2,
    parameter int SCNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    input  logic                ex_valid,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                ex_whilo,
    input  logic [2*DATA_W-1:0] acc_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic [2*DATA_W-1:0] acc_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic                mem_valid,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_whilo,
    output logic [SCNT_W-1:0]   stall_cycles,
    output logic                stall_sat
);

    localparam logic [SCNT_W-1:0] SCNT_MAX = '1;

    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_ADVANCE,
        ACT_HOLD
    } action_t;

    logic              s0;
    logic              s1;
    action_t           action;
    logic [SCNT_W-1:0] stall_cnt_nxt;

    assign s0 = stall[STAGE];
    assign s1 = stall[STAGE+1];

    // NOTE: every variable gets a default first so no latch is inferred.
    always_comb begin
        action = ACT_HOLD;
        if (flush)    action = ACT_FLUSH;
        else if (!s0) action = ACT_ADVANCE;
        else if (!s1) action = ACT_BUBBLE;
    end

    always_comb begin
        stall_cnt_nxt = stall_cycles;
        if (flush || !s0)                 stall_cnt_nxt = '0;
        else if (stall_cycles != SCNT_MAX) stall_cnt_nxt = stall_cycles + 1'b1;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid    <= 1'b0;
            mem_wd       <= '0;
            mem_wdata    <= '0;
            mem_wreg     <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_whilo    <= 1'b0;
            acc_o        <= '0;
            cnt_o        <= '0;
            stall_cycles <= '0;
            stall_sat    <= 1'b0;
        end else begin
            stall_cycles <= stall_cnt_nxt;
            stall_sat    <= (stall_cnt_nxt == SCNT_MAX);
            unique case (action)
                ACT_FLUSH, ACT_BUBBLE: begin
                    mem_valid <= 1'b0;
                    mem_wd    <= '0;
                    mem_wdata <= '0;
                    mem_wreg  <= 1'b0;
                    mem_hi    <= '0;
                    mem_lo    <= '0;
                    mem_whilo <= 1'b0;
                    // A flush aborts the in-flight multi-cycle op; a bubble keeps it going.
                    acc_o     <= (action == ACT_FLUSH) ? '0 : acc_i;
                    cnt_o     <= (action == ACT_FLUSH) ? '0 : cnt_i;
                end
                ACT_ADVANCE: begin
                    mem_valid <= ex_valid;
                    mem_wd    <= ex_wd;
                    mem_wdata <= ex_wdata;
                    mem_wreg  <= ex_wreg & ex_valid;
                    mem_hi    <= ex_hi;
                    mem_lo    <= ex_lo;
                    mem_whilo <= ex_whilo & ex_valid;
                    acc_o     <= '0;
                    cnt_o     <= '0;
                end
                default: begin
                    acc_o <= acc_i;
                    cnt_o <= cnt_i;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: directed steps plus a short random run,
// expected outputs queued when stimulus is driven and compared after each edge.
module tb_ex_mem_pipe_reg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int STALL_W = 6;
    localparam int STAGE   = 3;
    localparam int CNT_W   = 2;
    localparam int SCNT_W  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [STALL_W-1:0]  stall;
    logic                flush;
    logic                ex_valid;
    logic [ADDR_W-1:0]   ex_wd;
    logic [DATA_W-1:0]   ex_wdata;
    logic                ex_wreg;
    logic [DATA_W-1:0]   ex_hi;
    logic [DATA_W-1:0]   ex_lo;
    logic                ex_whilo;
    logic [2*DATA_W-1:0] acc_i;
    logic [CNT_W-1:0]    cnt_i;
    logic [2*DATA_W-1:0] acc_o;
    logic [CNT_W-1:0]    cnt_o;
    logic                mem_valid;
    logic [ADDR_W-1:0]   mem_wd;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_wreg;
    logic [DATA_W-1:0]   mem_hi;
    logic [DATA_W-1:0]   mem_lo;
    logic                mem_whilo;
    logic [SCNT_W-1:0]   stall_cycles;
    logic                stall_sat;

    ex_mem_pipe_reg #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STALL_W(STALL_W),
        .STAGE(STAGE), .CNT_W(CNT_W), .SCNT_W(SCNT_W)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wdata(ex_wdata), .ex_wreg(ex_wreg),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .acc_i(acc_i), .cnt_i(cnt_i), .acc_o(acc_o), .cnt_o(cnt_o),
        .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wdata(mem_wdata), .mem_wreg(mem_wreg),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .stall_cycles(stall_cycles), .stall_sat(stall_sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                valid;
        logic [ADDR_W-1:0]   wd;
        logic [DATA_W-1:0]   wdata;
        logic                wreg;
        logic [DATA_W-1:0]   hi;
        logic [DATA_W-1:0]   lo;
        logic                whilo;
        logic [2*DATA_W-1:0] acc;
        logic [CNT_W-1:0]    cnt;
        logic [SCNT_W-1:0]   scyc;
        logic                ssat;
    } out_t;

    out_t model;
    out_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference behaviour of one clock edge, written from the action table.
    function automatic out_t next_model(input out_t m);
        out_t n = m;
        logic b0 = stall[STAGE];
        logic b1 = stall[STAGE+1];
        if (flush) begin
            n = '0;
        end else if (!b0) begin
            n.valid = ex_valid;
            n.wd    = ex_wd;
            n.wdata = ex_wdata;
            n.wreg  = ex_valid ? ex_wreg : 1'b0;
            n.hi    = ex_hi;
            n.lo    = ex_lo;
            n.whilo = ex_valid ? ex_whilo : 1'b0;
            n.acc   = '0;
            n.cnt   = '0;
            n.scyc  = '0;
        end else begin
            if (!b1) begin
                n.valid = 1'b0; n.wd = '0; n.wdata = '0; n.wreg = 1'b0;
                n.hi = '0; n.lo = '0; n.whilo = 1'b0;
            end
            n.acc = acc_i;
            n.cnt = cnt_i;
            if (m.scyc != 4'hF) n.scyc = m.scyc + 4'd1;
        end
        n.ssat = (n.scyc == 4'hF);
        return n;
    endfunction

    task automatic compare_outputs(input string tag, input out_t e);
        check({tag, ".mem_valid"}, 64'(mem_valid), 64'(e.valid));
        check({tag, ".mem_wd"}, 64'(mem_wd), 64'(e.wd));
        check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(e.wdata));
        check({tag, ".mem_wreg"}, 64'(mem_wreg), 64'(e.wreg));
        check({tag, ".mem_hi"}, 64'(mem_hi), 64'(e.hi));
        check({tag, ".mem_lo"}, 64'(mem_lo), 64'(e.lo));
        check({tag, ".mem_whilo"}, 64'(mem_whilo), 64'(e.whilo));
        check({tag, ".acc_o"}, acc_o, e.acc);
        check({tag, ".cnt_o"}, 64'(cnt_o), 64'(e.cnt));
        check({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(e.scyc));
        check({tag, ".stall_sat"}, 64'(stall_sat), 64'(e.ssat));
    endtask

    // Drive current inputs through one edge: queue expectation, then pop and compare.
    task automatic step(input string tag);
        out_t e;
        model = next_model(model);
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        compare_outputs(tag, e);
    endtask

    task automatic idle_inputs();
        stall = '0; flush = 1'b0; ex_valid = 1'b0; ex_wd = '0; ex_wdata = '0;
        ex_wreg = 1'b0; ex_hi = '0; ex_lo = '0; ex_whilo = 1'b0; acc_i = '0; cnt_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        model = '0;
        rst = 1'b1;
        #12;
        compare_outputs("reset_init", '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Load a payload, then hit async reset between edges.
        ex_valid = 1'b1; ex_wd = 5'd3; ex_wdata = 32'hDEADBEEF; ex_wreg = 1'b1;
        ex_hi = 32'h1111_2222; ex_whilo = 1'b1;
        step("pre_reset");
        #2 rst = 1'b1;
        #1;
        model = '0;
        compare_outputs("async_reset", '0);
        #1 rst = 1'b0;

        // Advance.
        idle_inputs();
        ex_valid = 1'b1; ex_wd = 5'd7; ex_wdata = 32'h12345678; ex_wreg = 1'b1;
        step("advance");
        check("advance.wd_const", 64'(mem_wd), 64'd7);
        check("advance.wdata_const", 64'(mem_wdata), 64'h12345678);

        // Bubble with accumulator carry.
        stall = 6'b001111; acc_i = 64'h0000_0001_0000_0002; cnt_i = 2'b01;
        step("bubble");
        check("bubble.acc_const", acc_o, 64'h0000_0001_0000_0002);
        check("bubble.valid_const", 64'(mem_valid), 64'd0);

        // Hold: payload frozen while EX data changes.
        idle_inputs();
        ex_valid = 1'b1; ex_wd = 5'd9; ex_wdata = 32'hA5A5A5A5; ex_wreg = 1'b1;
        step("hold_load");
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            ex_wdata = 32'h1000 + 32'(i); acc_i = 64'(i + 5); cnt_i = 2'(i);
            step("hold");
        end
        check("hold.wdata_const", 64'(mem_wdata), 64'hA5A5A5A5);
        check("hold.scyc_const", 64'(stall_cycles), 64'd3);
        stall = '0; ex_wdata = 32'hCAFEF00D;
        step("hold_release");
        check("release.scyc_const", 64'(stall_cycles), 64'd0);

        // Flush overrides a bubble pattern.
        stall = 6'b001111; acc_i = 64'hFFFF_0000_1234_5678; cnt_i = 2'b11;
        step("pre_flush_bubble");
        flush = 1'b1;
        step("flush");
        check("flush.acc_const", acc_o, 64'd0);
        flush = 1'b0;

        // Saturation, then invalid-gated advance.
        stall = '0; step("sat_clear");
        stall = 6'b011000;
        for (int i = 0; i < 20; i++) step("saturate");
        check("sat.scyc_const", 64'(stall_cycles), 64'd15);
        check("sat.flag_const", 64'(stall_sat), 64'd1);
        stall = '0; ex_valid = 1'b0; ex_wreg = 1'b1; ex_whilo = 1'b1;
        step("invalid_gate");
        check("gate.wreg_const", 64'(mem_wreg), 64'd0);
        check("gate.whilo_const", 64'(mem_whilo), 64'd0);

        // Short random mix of all four actions.
        for (int i = 0; i < 40; i++) begin
            stall    = 6'($urandom_range(0, 63));
            flush    = ($urandom_range(0, 9) == 0);
            ex_valid = 1'($urandom);
            ex_wd    = 5'($urandom);
            ex_wdata = $urandom;
            ex_wreg  = 1'($urandom);
            ex_hi    = $urandom;
            ex_lo    = $urandom;
            ex_whilo = 1'($urandom);
            acc_i    = {$urandom, $urandom};
            cnt_i    = 2'($urandom);
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
